// File: rtl/dm_arbiter.sv
// Shares one DRAM port between NUM_CORES cores (round-robin FSM in RUN) and the com interface.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest core index wins) instead of round-robin.
module dm_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  status,
  input  logic [ADDR_W-1:0]           com_addr,
  input  logic [DATA_W-1:0]           com_data_in,
  input  logic                        com_wr_en,
  output logic [DATA_W-1:0]           com_data_out,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_wr_en,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic [NUM_CORES-1:0]        core_done,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           DM_addr,
  output logic [DATA_W-1:0]           DM_data_in,
  output logic                        DM_write_en,
  input  logic [DATA_W-1:0]           DM_out,
  output logic                        busy
);

  localparam int unsigned IdxW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0]  StatusRun = 2'b01;

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     win_q, pick_idx, cand_idx;
  logic                pick_found, run, load;
  logic [ADDR_W-1:0]   addr_q, sel_addr;
  logic [DATA_W-1:0]   wdata_q, sel_wdata, rdata_q;
  logic                we_q, sel_we;
  logic [NUM_CORES-1:0] win_onehot;

  assign run  = (status == StatusRun);
  assign load = (state_q == StIdle) && run && pick_found;

`ifndef ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] rr_ptr_q;

  // Pointer holds the last winner; the search starts one past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= IdxW'(NUM_CORES - 1);
    end else if (load) begin
      rr_ptr_q <= pick_idx;
    end
  end
`endif

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand_idx = IdxW'(i - 1);
`else
      cand_idx = IdxW'((32'(rr_ptr_q) + i) % NUM_CORES);
`endif
      if (!pick_found && core_req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (pick_idx == IdxW'(i)) begin
        sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[i*DATA_W +: DATA_W];
        sel_we    = core_wr_en[i];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      win_onehot[i] = (win_q == IdxW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (run && pick_found) state_d = StAccess;
      StAccess: state_d = we_q ? StDone : StResp;
      StResp:   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (load) begin
        win_q   <= pick_idx;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        we_q    <= sel_we;
      end
      // DRAM read data arrives one cycle after the ACCESS address.
      if (state_q == StResp) begin
        rdata_q <= DM_out;
      end
    end
  end

  always_comb begin
    DM_addr     = addr_q;
    DM_data_in  = wdata_q;
    DM_write_en = 1'b0;
    core_grant  = '0;
    core_done   = '0;
    unique case (state_q)
      StIdle: begin
        // Com owns the port only when idle, so a mid-transaction mode change cannot write.
        if (!run) begin
          DM_addr     = com_addr;
          DM_data_in  = com_data_in;
          DM_write_en = com_wr_en;
        end
      end
      StAccess: begin
        DM_write_en = we_q;
        core_grant  = win_onehot;
      end
      StResp: ;
      StDone: core_done = win_onehot;
      default: ;
    endcase
  end

  assign busy         = (state_q != StIdle);
  assign core_rdata   = rdata_q;
  assign com_data_out = DM_out;

endmodule
